// File: rtl/slice_sequencer.sv
// -----------------------------------------------------------------------------
// slice_sequencer
//
// Sequences one complete slicing job:
//   1. trigger the ultrasonic ranger and measure the total workpiece length,
//   2. compute segment = floor(length / slice_num) with a restoring divider
//      that produces one quotient bit per cycle (DIS_W cycles in DIVIDE),
//   3. repeat trigger / measure / cut until slice_num-1 cuts are made,
//   4. run the return stroke until the ranger reads at least the full length,
//      then pulse finish for one cycle.
// Pause pulses toggle in and out of PAUSE; abort returns to IDLE from any state.
//
// Parameters:
//   DIS_W        distance / length width
//   CNT_W        slice count width
//   TIMEOUT_CYC  cycles to wait for valid before retriggering (timeout build)
//   MAX_RETRY    consecutive timeouts tolerated before ERROR (timeout build)
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        level, begins a job when sampled in IDLE
//   pause        one-cycle pulse, toggles pause
//   abort        level, forces IDLE from any state and clears ERROR
//   slice_num    number of pieces, latched at start
//   valid        ranger result strobe, qualifies distance
//   distance     ranger result
//   trigger_suc  ranger accepted the trigger
//   cut_end      cut controller done pulse
//   trigger      ranger trigger request
//   move         carriage move enable
//   back         return-stroke direction
//   cut          cut request
//   finish       one-cycle job-complete pulse
//   busy         state != IDLE
//   error        high while in ERROR
//   slice_idx    cuts completed in the current job
//   state_o      current state code (debug)
//
// Optional feature macro: SLICE_SEQ_TIMEOUT_EN
//   When defined, a wait-cycle counter retriggers the ranger after TIMEOUT_CYC
//   cycles without valid and enters ERROR after MAX_RETRY+1 consecutive
//   timeouts. When undefined, the waiting states wait indefinitely.
// -----------------------------------------------------------------------------
module slice_sequencer #(
  parameter int DIS_W       = 17,
  parameter int CNT_W       = 6,
  parameter int TIMEOUT_CYC = 3000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [CNT_W-1:0] slice_num,
  input  logic             valid,
  input  logic [DIS_W-1:0] distance,
  input  logic             trigger_suc,
  input  logic             cut_end,
  output logic             trigger,
  output logic             move,
  output logic             back,
  output logic             cut,
  output logic             finish,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] slice_idx,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT_TRI = 4'd1,
    INIT_MEA = 4'd2,
    DIVIDE   = 4'd3,
    TRIGGER  = 4'd4,
    MEASURE  = 4'd5,
    CUT      = 4'd6,
    BACK_TRI = 4'd7,
    BACK     = 4'd8,
    PAUSE    = 4'd9,
    ERROR    = 4'd10
  } state_t;

  localparam int DIV_CW = $clog2(DIS_W + 1);

  // Reject parameter sets that make the timeout path meaningless.
  if (TIMEOUT_CYC < 1 || MAX_RETRY < 0) begin : g_bad_params
    $error("slice_sequencer: TIMEOUT_CYC must be >= 1 and MAX_RETRY >= 0");
  end

  state_t state;
  state_t state_next;
  state_t resume_state;
  state_t resume_next;

  logic [CNT_W-1:0] slice_num_r;
  logic [DIS_W-1:0] job_length;
  logic [DIS_W-1:0] location;
  logic [DIS_W-1:0] segment;
  logic [DIS_W-1:0] loc_minus_seg;

  logic [CNT_W-1:0]  div_rem;
  logic [DIS_W-1:0]  div_quo;
  logic [DIV_CW-1:0] div_cnt;
  logic [CNT_W:0]    div_trial;
  logic              div_ge;
  logic [CNT_W-1:0]  div_rem_next;
  logic [DIS_W-1:0]  div_quo_next;
  logic              div_last;

  logic timeout_hit;
  logic retry_exhausted;

  assign state_o = state;

  // Restoring divider step. The remainder never reaches the divisor, so it
  // fits in CNT_W bits; the dividend shifts out of div_quo MSB-first while
  // the quotient bits shift in from the bottom.
  always_comb begin
    div_trial    = {div_rem, div_quo[DIS_W-1]};
    div_ge       = (div_trial >= {1'b0, slice_num_r});
    div_rem_next = div_ge ? CNT_W'(div_trial - {1'b0, slice_num_r})
                          : div_trial[CNT_W-1:0];
    div_quo_next = {div_quo[DIS_W-2:0], div_ge};
    div_last     = (div_cnt == DIV_CW'(DIS_W - 1));
  end

  // Cut threshold: the next cut point along the workpiece, clamped at zero
  // so a segment larger than the remaining location cannot wrap around.
  always_comb begin
    loc_minus_seg = (location > segment) ? (location - segment) : '0;
  end

  // Next-state logic. Abort beats pause, pause beats the normal transition.
  // Entering PAUSE from a waiting state resumes at the matching trigger state
  // because the ranger result in flight is no longer trustworthy.
  always_comb begin
    state_next  = state;
    resume_next = resume_state;
    if (abort) begin
      state_next = IDLE;
    end else if (pause && (state != IDLE) && (state != DIVIDE) && (state != ERROR)) begin
      if (state == PAUSE) begin
        state_next = resume_state;
      end else begin
        state_next = PAUSE;
        case (state)
          INIT_MEA: resume_next = INIT_TRI;
          MEASURE:  resume_next = TRIGGER;
          BACK:     resume_next = BACK_TRI;
          default:  resume_next = state;
        endcase
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = (slice_num == '0) ? ERROR : INIT_TRI;
          end
        end
        INIT_TRI: begin
          if (trigger_suc) begin
            state_next = INIT_MEA;
          end
        end
        INIT_MEA: begin
          if (valid) begin
            state_next = DIVIDE;
          end else if (timeout_hit) begin
            state_next = retry_exhausted ? ERROR : INIT_TRI;
          end
        end
        DIVIDE: begin
          if (div_last) begin
            state_next = (slice_num_r == CNT_W'(1)) ? IDLE : TRIGGER;
          end
        end
        TRIGGER: begin
          if (trigger_suc) begin
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (valid) begin
            state_next = (distance <= loc_minus_seg) ? CUT : TRIGGER;
          end else if (timeout_hit) begin
            state_next = retry_exhausted ? ERROR : TRIGGER;
          end
        end
        CUT: begin
          if (cut_end) begin
            state_next = (slice_idx == (slice_num_r - CNT_W'(1))) ? BACK_TRI : TRIGGER;
          end
        end
        BACK_TRI: begin
          if (trigger_suc) begin
            state_next = BACK;
          end
        end
        BACK: begin
          if (valid) begin
            state_next = (distance >= job_length) ? IDLE : BACK_TRI;
          end else if (timeout_hit) begin
            state_next = retry_exhausted ? ERROR : BACK_TRI;
          end
        end
        PAUSE: begin
        end
        ERROR: begin
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and pause-resume registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      resume_state <= IDLE;
    end else begin
      state        <= state_next;
      resume_state <= resume_next;
    end
  end

  // Job datapath. Updates are keyed on the transition actually taken, so a
  // pause or abort arriving together with valid/cut_end cannot slip through.
  // Abort clears the cut count but deliberately keeps length and segment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_num_r <= '0;
      slice_idx   <= '0;
      job_length  <= '0;
      location    <= '0;
      segment     <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_cnt     <= '0;
    end else begin
      if (abort) begin
        slice_idx <= '0;
      end else if ((state == IDLE) && (state_next == INIT_TRI)) begin
        slice_num_r <= slice_num;
        slice_idx   <= '0;
      end else if ((state == MEASURE) && (state_next == CUT)) begin
        slice_idx <= slice_idx + CNT_W'(1);
      end

      if ((state == INIT_MEA) && (state_next == DIVIDE)) begin
        job_length <= distance;
        location   <= distance;
        div_quo    <= distance;
        div_rem    <= '0;
        div_cnt    <= '0;
      end else if ((state == DIVIDE) && !abort) begin
        div_quo <= div_quo_next;
        div_rem <= div_rem_next;
        div_cnt <= div_cnt + DIV_CW'(1);
        if (div_last) begin
          segment <= div_quo_next;
        end
      end

      if ((state == CUT) && ((state_next == TRIGGER) || (state_next == BACK_TRI))) begin
        location <= loc_minus_seg;
      end
    end
  end

  // Outputs are decoded from the next state and registered so they line up
  // cycle-for-cycle with state_o. finish fires only on a normal job end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger <= 1'b0;
      move    <= 1'b0;
      back    <= 1'b0;
      cut     <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      trigger <= (state_next == INIT_TRI) || (state_next == TRIGGER) || (state_next == BACK_TRI);
      move    <= (state_next == MEASURE) || (state_next == BACK);
      back    <= (state_next == BACK);
      cut     <= (state_next == CUT);
      error   <= (state_next == ERROR);
      busy    <= (state_next != IDLE);
      finish  <= !abort && (state_next == IDLE) && ((state == DIVIDE) || (state == BACK));
    end
  end

`ifdef SLICE_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 2);

  logic [TO_W-1:0] wait_cnt;
  logic [RT_W-1:0] retry_cnt;
  logic            in_wait;

  assign in_wait         = (state == INIT_MEA) || (state == MEASURE) || (state == BACK);
  assign timeout_hit     = in_wait && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign retry_exhausted = (retry_cnt == RT_W'(MAX_RETRY));

  // Counts cycles spent in one visit to a waiting state; any state change
  // (result, timeout, pause, abort) restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!in_wait || (state_next != state)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  // Consecutive-timeout count. Any accepted ranger result resets it; the
  // count saturates once exhausted because the FSM is then heading to ERROR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (abort || (state == IDLE)) begin
      retry_cnt <= '0;
    end else if (in_wait && !pause && valid) begin
      retry_cnt <= '0;
    end else if (in_wait && !pause && timeout_hit && !retry_exhausted) begin
      retry_cnt <= retry_cnt + RT_W'(1);
    end
  end
`else
  assign timeout_hit     = 1'b0;
  assign retry_exhausted = 1'b0;
`endif

endmodule

// File: tb/tb_slice_sequencer.sv
// -----------------------------------------------------------------------------
// tb_slice_sequencer
//
// Drives the sequencer as the ranger / cutter environment would, one job at a
// time. Expected behaviour is derived per job from the job parameters:
// segment = len / n, successive cut thresholds location - segment (clamped at
// 0), n-1 cuts, a DIS_W-cycle divide phase, and the state-to-output table.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_slice_sequencer;

  localparam int DIS_W = 17;
  localparam int CNT_W = 6;

  localparam int S_IDLE     = 0;
  localparam int S_INIT_TRI = 1;
  localparam int S_INIT_MEA = 2;
  localparam int S_DIVIDE   = 3;
  localparam int S_TRIGGER  = 4;
  localparam int S_MEASURE  = 5;
  localparam int S_CUT      = 6;
  localparam int S_BACK_TRI = 7;
  localparam int S_BACK     = 8;
  localparam int S_PAUSE    = 9;
  localparam int S_ERROR    = 10;

  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_START = 6'b000001;
  localparam logic [5:0] F_PAUSE = 6'b000010;
  localparam logic [5:0] F_ABORT = 6'b000100;
  localparam logic [5:0] F_VALID = 6'b001000;
  localparam logic [5:0] F_TSUC  = 6'b010000;
  localparam logic [5:0] F_CEND  = 6'b100000;

  logic             clk         = 1'b0;
  logic             rst_n       = 1'b0;
  logic             start       = 1'b0;
  logic             pause       = 1'b0;
  logic             abort       = 1'b0;
  logic             valid       = 1'b0;
  logic             trigger_suc = 1'b0;
  logic             cut_end     = 1'b0;
  logic [CNT_W-1:0] slice_num   = '0;
  logic [DIS_W-1:0] distance    = '0;
  logic             trigger;
  logic             move;
  logic             back;
  logic             cut;
  logic             finish;
  logic             busy;
  logic             error;
  logic [CNT_W-1:0] slice_idx;
  logic [3:0]       state_o;

  int n_checks = 0;
  int n_fail   = 0;

  slice_sequencer #(
    .DIS_W(DIS_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .slice_num  (slice_num),
    .valid      (valid),
    .distance   (distance),
    .trigger_suc(trigger_suc),
    .cut_end    (cut_end),
    .trigger    (trigger),
    .move       (move),
    .back       (back),
    .cut        (cut),
    .finish     (finish),
    .busy       (busy),
    .error      (error),
    .slice_idx  (slice_idx),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Compares one observed value against its expected value and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Output pattern {trigger, move, back, cut, error, busy} for each state.
  function automatic logic [5:0] expOuts(input int s);
    case (s)
      S_IDLE:                          return 6'b000000;
      S_INIT_TRI, S_TRIGGER, S_BACK_TRI: return 6'b100001;
      S_MEASURE:                       return 6'b010001;
      S_CUT:                           return 6'b000101;
      S_BACK:                          return 6'b011001;
      S_ERROR:                         return 6'b000011;
      default:                         return 6'b000001;
    endcase
  endfunction

  task automatic checkState(input string tag, input int s, input logic fin = 1'b0);
    checkOutput({tag, " state"}, 32'(state_o), 32'(s));
    checkOutput({tag, " outs"}, 32'({trigger, move, back, cut, error, busy}), 32'(expOuts(s)));
    checkOutput({tag, " finish"}, 32'(finish), 32'(fin));
  endtask

  // Holds the selected inputs for exactly one rising edge, then releases them.
  task automatic applyStimulus(input logic [5:0] f, input logic [DIS_W-1:0] d = '0);
    start       = f[0];
    pause       = f[1];
    abort       = f[2];
    valid       = f[3];
    trigger_suc = f[4];
    cut_end     = f[5];
    distance    = d;
    @(negedge clk);
    start       = 1'b0;
    pause       = 1'b0;
    abort       = 1'b0;
    valid       = 1'b0;
    trigger_suc = 1'b0;
    cut_end     = 1'b0;
  endtask

  function automatic int satSub(input int a, input int b);
    return (a > b) ? (a - b) : 0;
  endfunction

  task automatic runJob(input int n, input int len, input bit directed);
    int seg;
    int loc;
    int thr;
    int d;
    seg = (n > 0) ? (len / n) : 0;
    loc = len;
    slice_num = CNT_W'(n);
    applyStimulus(F_START);
    if (n == 0) begin
      checkState("zero start", S_ERROR);
      applyStimulus(F_PAUSE);
      checkState("error pause", S_ERROR);
      applyStimulus(F_START);
      checkState("error hold", S_ERROR);
      applyStimulus(F_ABORT);
      checkState("error abort", S_IDLE);
      return;
    end
    checkState("start", S_INIT_TRI);
    checkOutput("start idx", 32'(slice_idx), 0);
    slice_num = CNT_W'($urandom);
    applyStimulus(F_VALID, DIS_W'($urandom));
    checkState("init_tri valid ignored", S_INIT_TRI);
    if (!directed && ($urandom_range(1, 0) == 1)) begin
      applyStimulus(F_PAUSE);
      checkState("init_tri pause", S_PAUSE);
      applyStimulus(F_PAUSE);
      checkState("init_tri resume", S_INIT_TRI);
    end
    applyStimulus(F_TSUC);
    checkState("init_mea", S_INIT_MEA);
    if (!directed && ($urandom_range(1, 0) == 1)) begin
      applyStimulus(F_PAUSE | F_VALID, DIS_W'(len));
      checkState("init_mea pause", S_PAUSE);
      applyStimulus(F_PAUSE);
      checkState("init_mea resume", S_INIT_TRI);
      applyStimulus(F_TSUC);
      checkState("init_mea again", S_INIT_MEA);
    end
    applyStimulus(F_VALID, DIS_W'(len));
    checkState("divide entry", S_DIVIDE);
    for (int i = 1; i < DIS_W; i++) begin
      applyStimulus((i == 5) ? F_PAUSE : F_NONE);
      checkState("divide", S_DIVIDE);
    end
    applyStimulus(F_NONE);
    if (n == 1) begin
      checkState("single finish", S_IDLE, 1'b1);
      applyStimulus(F_NONE);
      checkState("single after", S_IDLE);
      return;
    end
    checkState("divide exit", S_TRIGGER);
    for (int k = 1; k < n; k++) begin
      thr = satSub(loc, seg);
      applyStimulus(F_TSUC);
      checkState("measure", S_MEASURE);
      if (directed ? (k == 1) : ($urandom_range(2, 0) == 0)) begin
        d = thr + 1 + (directed ? 0 : int'($urandom_range(50, 0)));
        applyStimulus(F_VALID, DIS_W'(d));
        checkState("miss", S_TRIGGER);
        applyStimulus(F_TSUC);
        checkState("measure again", S_MEASURE);
      end
      if (directed ? (k == 1) : ($urandom_range(3, 0) == 0)) begin
        applyStimulus(F_PAUSE | F_VALID, '0);
        checkState("measure pause", S_PAUSE);
        applyStimulus(F_PAUSE);
        checkState("measure resume", S_TRIGGER);
        applyStimulus(F_TSUC);
        checkState("measure resumed", S_MEASURE);
      end
      d = directed ? thr : int'($urandom_range(thr, 0));
      applyStimulus(F_VALID, DIS_W'(d));
      checkState("cut", S_CUT);
      checkOutput("cut idx", 32'(slice_idx), 32'(k));
      if (!directed && ($urandom_range(3, 0) == 0)) begin
        applyStimulus(F_PAUSE);
        checkState("cut pause", S_PAUSE);
        applyStimulus(F_CEND);
        checkState("cut_end in pause", S_PAUSE);
        applyStimulus(F_PAUSE);
        checkState("cut resume", S_CUT);
      end
      loc = satSub(loc, seg);
      applyStimulus(F_CEND);
      checkState("cut done", (k == n - 1) ? S_BACK_TRI : S_TRIGGER);
    end
    applyStimulus(F_TSUC);
    checkState("back", S_BACK);
    if ((len > 0) && (directed || ($urandom_range(1, 0) == 1))) begin
      applyStimulus(F_VALID, DIS_W'(len - 1));
      checkState("back short", S_BACK_TRI);
      applyStimulus(F_TSUC);
      checkState("back again", S_BACK);
    end
    if (!directed && ($urandom_range(2, 0) == 0)) begin
      applyStimulus(F_PAUSE);
      checkState("back pause", S_PAUSE);
      applyStimulus(F_PAUSE);
      checkState("back resume", S_BACK_TRI);
      applyStimulus(F_TSUC);
      checkState("back resumed", S_BACK);
    end
    applyStimulus(F_VALID, DIS_W'(len + (directed ? 0 : int'($urandom_range(50, 0)))));
    checkState("job finish", S_IDLE, 1'b1);
    checkOutput("final idx", 32'(slice_idx), 32'(n - 1));
    applyStimulus(F_NONE);
    checkState("post finish", S_IDLE);
  endtask

  // Brings a fresh two-piece job of length len up to its first CUT.
  task automatic reachCut(input int len);
    slice_num = CNT_W'(2);
    applyStimulus(F_START);
    applyStimulus(F_TSUC);
    applyStimulus(F_VALID, DIS_W'(len));
    repeat (DIS_W) applyStimulus(F_NONE);
    applyStimulus(F_TSUC);
    checkState("reach measure", S_MEASURE);
    applyStimulus(F_VALID, '0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkState("reset", S_IDLE);
    checkOutput("reset idx", 32'(slice_idx), 0);
    rst_n = 1'b1;
    applyStimulus(F_PAUSE);
    checkState("idle pause ignored", S_IDLE);

    runJob(4, 1000, 1'b1);
    runJob(3, 100, 1'b1);
    runJob(0, 0, 1'b0);
    runJob(1, 5000, 1'b0);
    runJob(63, 10, 1'b0);

    // Abort from the middle of a job clears outputs without a finish pulse.
    slice_num = CNT_W'(5);
    applyStimulus(F_START);
    applyStimulus(F_TSUC);
    applyStimulus(F_VALID, DIS_W'(500));
    repeat (DIS_W) applyStimulus(F_NONE);
    applyStimulus(F_TSUC);
    applyStimulus(F_VALID, DIS_W'(400));
    checkState("pre-abort cut", S_CUT);
    applyStimulus(F_ABORT | F_CEND);
    checkState("abort", S_IDLE);
    checkOutput("abort idx", 32'(slice_idx), 0);

    for (int j = 0; j < 10; j++) begin
      runJob(int'($urandom_range(63, 1)), int'($urandom_range(120000, 0)), 1'b0);
    end

    // Asynchronous reset in the middle of a cut.
    reachCut(200);
    checkState("pre-reset cut", S_CUT);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset cut", 32'(cut), 0);
    checkOutput("async reset state", 32'(state_o), 0);
    checkOutput("async reset idx", 32'(slice_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(F_NONE);
    checkState("after reset", S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
